// File: rtl/dest_sel_pipe.sv
// Destination-register selector with registered output and one-entry skid buffer.
// Latency one cycle; in_ready drops only when the skid entry is occupied (max 2 beats held).
module dest_sel_pipe #(
   parameter int WIDTH = 5,
   parameter int NUM_IN = 4,
   parameter bit ZERO_SQUASH = 1'b1,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_we,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_dst,
   output logic                    out_we,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0] sel_dst;
   logic             sel_err;
   logic             sel_we;

   logic [WIDTH-1:0] o_dst;
   logic             o_we;
   logic             o_err;
   logic [WIDTH-1:0] s_dst;
   logic             s_we;
   logic             s_err;

   logic load_o;
   logic load_s;
   logic move_s;

   // Out-of-range selects decode to $zero and flag an error instead of aliasing.
   always_comb begin
      sel_dst = '0;
      sel_err = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (in_sel == i[SEL_W-1:0]) begin
            sel_dst = in_bus[i*WIDTH +: WIDTH];
            sel_err = 1'b0;
         end
      end
   end

   assign sel_we = in_we & ~sel_err & ~(ZERO_SQUASH & (sel_dst == '0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_valid) state_d = ST_ONE;
            ST_ONE: begin
               if (in_valid && !out_ready) begin
                  state_d = ST_FULL;
               end else if (!in_valid && out_ready) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL:  if (out_ready) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // Flush suppresses every payload move so a killed beat never reaches O or S.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      load_o    = 1'b0;
      load_s    = 1'b0;
      move_s    = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            load_o = in_valid & ~flush;
         end
         ST_ONE: begin
            out_valid = 1'b1;
            load_o    = in_valid & out_ready & ~flush;
            load_s    = in_valid & ~out_ready & ~flush;
         end
         ST_FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            move_s    = out_ready & ~flush;
         end
         default: begin
            in_ready = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_dst <= '0;
         o_we  <= 1'b0;
         o_err <= 1'b0;
         s_dst <= '0;
         s_we  <= 1'b0;
         s_err <= 1'b0;
      end else begin
         if (load_o) begin
            o_dst <= sel_dst;
            o_we  <= sel_we;
            o_err <= sel_err;
         end else if (move_s) begin
            o_dst <= s_dst;
            o_we  <= s_we;
            o_err <= s_err;
         end
         if (load_s) begin
            s_dst <= sel_dst;
            s_we  <= sel_we;
            s_err <= sel_err;
         end
      end
   end

   assign out_dst = o_dst;
   assign out_we  = o_we;
   assign out_err = o_err;

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Bench for dest_sel_pipe: three parameter variants share one stimulus stream and
// are compared each cycle against a queue-based reference of held beats.
module tb_dest_sel_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [19:0] in_bus;
   logic [1:0]  in_sel;
   logic        in_we;
   logic        in_valid;
   logic        flush;
   logic        out_ready;

   logic [2:0] rdy_o;
   logic [2:0] vld_o;
   logic [2:0] we_o;
   logic [2:0] err_o;
   logic [4:0] dst_o [3];
   logic [26:0] obs;

   int total = 0;
   int bad = 0;

   dest_sel_pipe #(.WIDTH(5), .NUM_IN(4), .ZERO_SQUASH(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_sel(in_sel), .in_we(in_we),
      .in_valid(in_valid), .in_ready(rdy_o[0]), .flush(flush), .out_dst(dst_o[0]),
      .out_we(we_o[0]), .out_err(err_o[0]), .out_valid(vld_o[0]), .out_ready(out_ready));

   dest_sel_pipe #(.WIDTH(5), .NUM_IN(3), .ZERO_SQUASH(1'b1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_bus(in_bus[14:0]), .in_sel(in_sel), .in_we(in_we),
      .in_valid(in_valid), .in_ready(rdy_o[1]), .flush(flush), .out_dst(dst_o[1]),
      .out_we(we_o[1]), .out_err(err_o[1]), .out_valid(vld_o[1]), .out_ready(out_ready));

   dest_sel_pipe #(.WIDTH(5), .NUM_IN(4), .ZERO_SQUASH(1'b0)) u_dutz (
      .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_sel(in_sel), .in_we(in_we),
      .in_valid(in_valid), .in_ready(rdy_o[2]), .flush(flush), .out_dst(dst_o[2]),
      .out_we(we_o[2]), .out_err(err_o[2]), .out_valid(vld_o[2]), .out_ready(out_ready));

   assign obs = {rdy_o[0], vld_o[0], dst_o[0], we_o[0], err_o[0],
                 rdy_o[1], vld_o[1], dst_o[1], we_o[1], err_o[1],
                 rdy_o[2], vld_o[2], dst_o[2], we_o[2], err_o[2]};

   // Reference: beats held by the block, plus the last beat shown on the outputs.
   typedef struct packed {
      logic [19:0] bus;
      logic [1:0]  sel;
      logic        we;
   } req_t;

   req_t q[$];
   req_t shown = '0;
   int   num_v[3] = '{4, 3, 4};
   bit   zs_v[3]  = '{1'b1, 1'b1, 1'b0};

   function automatic logic [6:0] ref_beat(req_t r, int num, bit zs);
      logic [19:0] b;
      logic [4:0]  d;
      logic        e;
      logic        w;
      b = r.bus;
      if (int'(r.sel) < num) begin
         d = b[int'(r.sel)*5 +: 5];
         e = 1'b0;
      end else begin
         d = 5'd0;
         e = 1'b1;
      end
      w = r.we && !e && !(zs && d == 5'd0);
      return {d, w, e};
   endfunction

   function automatic logic [26:0] expect_vec();
      logic [26:0] v;
      logic        r;
      logic        s;
      v = '0;
      r = (q.size() < 2) ? 1'b1 : 1'b0;
      s = (q.size() > 0) ? 1'b1 : 1'b0;
      for (int k = 0; k < 3; k++) begin
         v[(2-k)*9 +: 9] = {r, s, ref_beat(shown, num_v[k], zs_v[k])};
      end
      return v;
   endfunction

   // Advance the model with the current inputs, then clock the DUTs.
   task automatic cycle();
      req_t r;
      bit   do_in;
      bit   do_out;
      r.bus = in_bus;
      r.sel = in_sel;
      r.we  = in_we;
      if (!rst_n) begin
         q.delete();
         shown = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         do_in  = in_valid && q.size() < 2;
         do_out = q.size() > 0 && out_ready;
         if (do_out) void'(q.pop_front());
         if (do_in) q.push_back(r);
         if (q.size() > 0) shown = q[0];
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b0;
      flush = 1'b0;
      in_bus = 20'hABCDE;
      cycle();
      total++;
      if (obs !== {3{9'h100}}) begin
         bad++;
         $display("FAIL reset got=%h want=%h", obs, {3{9'h100}});
      end
      total++;
      if (obs !== expect_vec()) begin
         bad++;
         $display("FAIL reset_model got=%h want=%h", obs, expect_vec());
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
   endtask

   task automatic test_basic_select();
      logic [4:0] exp_d [4] = '{5'd8, 5'd17, 5'd31, 5'd0};
      logic       exp_w [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      in_bus = {5'd0, 5'd31, 5'd17, 5'd8};
      out_ready = 1'b1;
      in_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_sel = 2'(i);
         cycle();
         total++;
         if ({vld_o[0], dst_o[0], we_o[0]} !== {1'b1, exp_d[i], exp_w[i]}) begin
            bad++;
            $display("FAIL basic_sel%0d got=%b/%0d/%b want=1/%0d/%b", i, vld_o[0], dst_o[0], we_o[0], exp_d[i], exp_w[i]);
         end
         total++;
         if (obs !== expect_vec()) begin
            bad++;
            $display("FAIL basic_model%0d got=%h want=%h", i, obs, expect_vec());
         end
      end
      in_valid = 1'b0;
      cycle();
      total++;
      if (obs !== expect_vec() || vld_o[0] !== 1'b0) begin
         bad++;
         $display("FAIL basic_drain got=%h want=%h", obs, expect_vec());
      end
   endtask

   task automatic test_invalid_select();
      in_bus = {5'd9, 5'd7, 5'd6, 5'd5};
      in_sel = 2'd3;
      in_we = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      cycle();
      total++;
      if ({vld_o[1], dst_o[1], we_o[1], err_o[1]} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL invalid_sel got=%b/%0d/%b/%b want=1/0/0/1", vld_o[1], dst_o[1], we_o[1], err_o[1]);
      end
      total++;
      if (obs !== expect_vec()) begin
         bad++;
         $display("FAIL invalid_model got=%h want=%h", obs, expect_vec());
      end
      in_valid = 1'b0;
      cycle();
   endtask

   task automatic test_zero_squash_off();
      in_bus = {5'd3, 5'd9, 5'd0, 5'd12};
      in_sel = 2'd1;
      in_we = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      cycle();
      total++;
      if ({vld_o[2], dst_o[2], we_o[2], err_o[2]} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL nosquash got=%b/%0d/%b/%b want=1/0/1/0", vld_o[2], dst_o[2], we_o[2], err_o[2]);
      end
      total++;
      if (we_o[0] !== 1'b0) begin
         bad++;
         $display("FAIL squash got=%b want=0", we_o[0]);
      end
      in_valid = 1'b0;
      cycle();
   endtask

   task automatic test_backpressure();
      logic [1:0] sels [3] = '{2'd0, 2'd1, 2'd2};
      logic [4:0] want [3] = '{5'd1, 5'd2, 5'd3};
      logic [4:0] got [$];
      int sent = 0;
      bit acc;
      in_bus = {5'd4, 5'd3, 5'd2, 5'd1};
      in_we = 1'b1;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = (sent < 3);
         in_sel = sels[sent < 3 ? sent : 2];
         acc = in_valid && rdy_o[0];
         cycle();
         if (acc) sent++;
         total++;
         if (obs !== expect_vec()) begin
            bad++;
            $display("FAIL bp_hold%0d got=%h want=%h", c, obs, expect_vec());
         end
      end
      total++;
      if (sent !== 2 || rdy_o[0] !== 1'b0) begin
         bad++;
         $display("FAIL bp_absorb got=%0d/%b want=2/0", sent, rdy_o[0]);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (sent < 3);
         in_sel = sels[sent < 3 ? sent : 2];
         acc = in_valid && rdy_o[0];
         if (vld_o[0]) got.push_back(dst_o[0]);
         cycle();
         if (acc) sent++;
         total++;
         if (obs !== expect_vec()) begin
            bad++;
            $display("FAIL bp_drain%0d got=%h want=%h", c, obs, expect_vec());
         end
      end
      total++;
      if (got.size() !== 3) begin
         bad++;
         $display("FAIL bp_count got=%0d want=3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (got[i] !== want[i]) begin
               bad++;
               $display("FAIL bp_order%0d got=%0d want=%0d", i, got[i], want[i]);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      in_bus = {5'd14, 5'd13, 5'd12, 5'd11};
      in_we = 1'b1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         in_sel = 2'(c);
         cycle();
      end
      total++;
      if (rdy_o[0] !== 1'b0 || obs !== expect_vec()) begin
         bad++;
         $display("FAIL flush_fill got=%h want=%h", obs, expect_vec());
      end
      in_sel = 2'd2;
      flush = 1'b1;
      out_ready = 1'b1;
      cycle();
      total++;
      if (vld_o[0] !== 1'b0 || rdy_o[0] !== 1'b1 || obs !== expect_vec()) begin
         bad++;
         $display("FAIL flush_full got=%h want=%h", obs, expect_vec());
      end
      flush = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         total++;
         if (vld_o !== 3'b000 || obs !== expect_vec()) begin
            bad++;
            $display("FAIL flush_after%0d got=%h want=%h", c, obs, expect_vec());
         end
      end
      flush = 1'b1;
      cycle();
      total++;
      if (vld_o !== 3'b000 || obs !== expect_vec()) begin
         bad++;
         $display("FAIL flush_empty got=%h want=%h", obs, expect_vec());
      end
      flush = 1'b0;
   endtask

   task automatic test_reset_mid();
      in_bus = {5'd22, 5'd21, 5'd20, 5'd19};
      in_we = 1'b1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_sel = 2'd0;
      cycle();
      cycle();
      rst_n = 1'b0;
      cycle();
      total++;
      if (obs !== {3{9'h100}}) begin
         bad++;
         $display("FAIL rst_mid got=%h want=%h", obs, {3{9'h100}});
      end
      rst_n = 1'b1;
      in_sel = 2'd2;
      out_ready = 1'b1;
      cycle();
      total++;
      if ({vld_o[0], dst_o[0], we_o[0]} !== {1'b1, 5'd21, 1'b1} || obs !== expect_vec()) begin
         bad++;
         $display("FAIL rst_next got=%b/%0d/%b want=1/21/1", vld_o[0], dst_o[0], we_o[0]);
      end
      in_valid = 1'b0;
      cycle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 29) == 0);
         rst_n = ($urandom_range(0, 99) != 0);
         in_sel = 2'($urandom_range(0, 3));
         in_we = 1'($urandom_range(0, 1));
         in_bus = 20'($urandom);
         if ($urandom_range(0, 2) == 0) in_bus[$urandom_range(0, 3)*5 +: 5] = 5'd0;
         cycle();
         total++;
         if (obs !== expect_vec()) begin
            bad++;
            $display("FAIL random%0d got=%h want=%h", c, obs, expect_vec());
         end
      end
      rst_n = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      in_bus = '0;
      in_sel = '0;
      in_we = 1'b0;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_basic_select();
      test_invalid_select();
      test_zero_squash_off();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
